// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: IDLE -> REQ -> WAIT -> ISSUE, one word per control-unit retirement.
// Optional build macro FETCH_HALT_EN adds halt-on-16'hFFFF detection.
module fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_data,
    output logic [15:0]       instruction,
    output logic              run,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, ISSUE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc_next, addr_next;
    logic [15:0]       instr_next;
    logic              run_next, rd_en_next, halt_next, halted_q;
    logic              halt_word;

`ifdef FETCH_HALT_EN
    assign halt_word = (mem_data == 16'hFFFF);
    assign halted    = halted_q;
`else
    assign halt_word = 1'b0;
    assign halted    = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_next = state;
        pc_next    = pc;
        instr_next = instruction;
        run_next   = run;
        halt_next  = halted_q;
        case (state)
            IDLE:  if (start && !halted_q) state_next = REQ;
            REQ:   state_next = WAIT;
            WAIT: begin
                if (halt_word) begin
                    // Halt word is never issued; the FSM parks until reset.
                    halt_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    instr_next = mem_data;
                    run_next   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (done) begin
                    run_next   = 1'b0;
                    pc_next    = pc + ADDR_W'(1);
                    state_next = start ? REQ : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with the state itself.
        rd_en_next = (state_next == REQ);
        addr_next  = rd_en_next ? pc_next : mem_addr;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst) begin
            state       <= IDLE;
            pc          <= RST_PC;
            instruction <= 16'h0000;
            run         <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= RST_PC;
            halted_q    <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instruction <= instr_next;
            run         <= run_next;
            mem_rd_en   <= rd_en_next;
            mem_addr    <= addr_next;
            halted_q    <= halt_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: default instance plus a 4-bit instance starting at pc 15.
// Covers the FETCH_HALT_EN build when that macro is defined.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, start, done;
    logic        mem_rd_en, run, halted;
    logic [7:0]  mem_addr, pc;
    logic [15:0] mem_data, instruction;

    logic        b_start, b_done, b_rd_en, b_run, b_halted;
    logic [3:0]  b_addr, b_pc;
    logic [15:0] b_data, b_instr;

    logic [15:0] mem [256];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .instruction(instruction), .run(run), .pc(pc), .halted(halted)
    );

    fetch_unit #(.ADDR_W(4), .RESET_PC(15)) dut4 (
        .clk(clk), .rst(rst), .start(b_start), .done(b_done),
        .mem_rd_en(b_rd_en), .mem_addr(b_addr), .mem_data(b_data),
        .instruction(b_instr), .run(b_run), .pc(b_pc), .halted(b_halted)
    );

    // Read data appears one cycle after a strobe; other cycles carry junk that must be ignored.
    always @(posedge clk) begin
        mem_data <= mem_rd_en ? mem[mem_addr] : 16'hDEAD;
        b_data   <= b_rd_en ? {12'h0C0, b_addr} : 16'hBEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'hABCD;
        mem[3] = 16'hFFFF; mem[4] = 16'h0042; mem[5] = 16'h0777;

        rst = 1'b0; start = 1'b0; done = 1'b0; b_start = 1'b0; b_done = 1'b0;
        step(2);
        check("rst_run", run, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_pc", pc, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_instr", instruction, 16'h0000);
        check("rst_halted", halted, 0);
        check("rst_b_pc", b_pc, 15);
        check("rst_b_addr", b_addr, 15);

        rst = 1'b1;
        step(1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        check("idle_stray_done_rd", mem_rd_en, 0);
        check("idle_stray_done_run", run, 0);
        check("idle_stray_done_pc", pc, 0);

        start = 1'b1;
        step(1);
        check("req0_rd_en", mem_rd_en, 1);
        check("req0_addr", mem_addr, 0);
        check("req0_run", run, 0);
        step(1);
        check("wait0_rd_en", mem_rd_en, 0);
        check("wait0_run", run, 0);
        done = 1'b1;
        step(1);
        done = 1'b0;
        check("issue0_run", run, 1);
        check("issue0_instr", instruction, 16'h1234);
        check("issue0_pc", pc, 0);
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("hold_run", run, 1);
            check("hold_instr", instruction, 16'h1234);
            check("hold_pc", pc, 0);
        end

        done = 1'b1;
        step(1);
        done = 1'b0;
        check("retire0_run", run, 0);
        check("retire0_pc", pc, 1);
        check("req1_rd_en", mem_rd_en, 1);
        check("req1_addr", mem_addr, 1);
        step(2);
        check("issue1_run", run, 1);
        check("issue1_instr", instruction, 16'h5678);
        step(3);
        done = 1'b1;
        step(1);
        done = 1'b0;
        check("retire1_pc", pc, 2);
        check("req2_addr", mem_addr, 2);

        step(1);
        start = 1'b0;
        step(1);
        check("issue2_run", run, 1);
        check("issue2_instr", instruction, 16'hABCD);
        step(2);
        check("issue2_start_low_run", run, 1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        check("retire2_run", run, 0);
        check("retire2_pc", pc, 3);
        check("retire2_idle_rd", mem_rd_en, 0);
        step(2);
        check("idle_after_drop_rd", mem_rd_en, 0);

        start = 1'b1;
        step(1);
        check("req3_addr", mem_addr, 3);
        step(2);
`ifdef FETCH_HALT_EN
        check("halt_flag", halted, 1);
        check("halt_run", run, 0);
        check("halt_pc", pc, 3);
        for (int i = 0; i < 6; i++) begin
            step(1);
            check("halt_no_rd", mem_rd_en, 0);
        end
        rst = 1'b0;
        step(1);
        check("halt_rst_flag", halted, 0);
        check("halt_rst_pc", pc, 0);
        rst = 1'b1;
        start = 1'b0;
        step(1);
`else
        check("ffff_run", run, 1);
        check("ffff_instr", instruction, 16'hFFFF);
        check("ffff_halted", halted, 0);
        done = 1'b1;
        step(1);
        done = 1'b0;
        check("retire3_pc", pc, 4);
        step(2);
        check("issue4_instr", instruction, 16'h0042);
        done = 1'b1;
        step(1);
        done = 1'b0;
        step(2);
        check("issue5_pc", pc, 5);
        check("issue5_instr", instruction, 16'h0777);
        rst = 1'b0;
        step(1);
        check("midrst_run", run, 0);
        check("midrst_pc", pc, 0);
        check("midrst_instr", instruction, 16'h0000);
        check("midrst_rd", mem_rd_en, 0);
        check("midrst_addr", mem_addr, 0);
        rst = 1'b1;
        step(1);
        check("restart_rd", mem_rd_en, 1);
        check("restart_addr", mem_addr, 0);
        start = 1'b0;
        step(1);
`endif

        b_start = 1'b1;
        step(1);
        check("b_req_addr", b_addr, 15);
        check("b_req_rd", b_rd_en, 1);
        step(2);
        check("b_issue_run", b_run, 1);
        check("b_issue_instr", b_instr, 16'h0C0F);
        b_start = 1'b0;
        b_done  = 1'b1;
        step(1);
        b_done  = 1'b0;
        check("b_wrap_pc", b_pc, 0);
        check("b_wrap_run", b_run, 0);
        check("b_wrap_halted", b_halted, 0);
        b_start = 1'b1;
        step(1);
        check("b_next_addr", b_addr, 0);
        check("b_next_rd", b_rd_en, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
